// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM state encodings, register offsets and status bit positions.
package bus_uart_pkg;

  // Transmit FSM states; S_PARITY is only reachable when BUS_UART_PARITY_EN is defined.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_t;

  // Register offsets relative to BASE_ADDR.
  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd1;

  // Bit positions inside the status register.
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  // Even parity of a data byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Synchronous FIFO with registered read data, used as the UART TX buffer.
//
// Handshake: push is accepted only while full is low, pop only while empty
// is low; a request against a full/empty FIFO is ignored. rd_data is updated
// on the edge that accepts a pop and holds that entry afterwards. Because pop
// needs a non-empty FIFO there is no write-through path.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array: written on accepted pushes, not reset (contents are don't-care when empty).
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered read data; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter on the shared CPU bus.
// Data register at BASE_ADDR (write pushes a byte), status register at
// BASE_ADDR+1 (read returns {5'b0, overflow, full, busy}, clears overflow).
// Frames are 8N1; defining BUS_UART_PARITY_EN inserts an even parity bit.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hF200,
  parameter int          BAUD_DIV   = 104,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic        writeEnBus,
  input  logic [7:0]  data_c2r,
  output logic [7:0]  data_r2c,
  output logic        rd_sel,
  output logic        tx
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  uart_state_t state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        load_pending;
  logic        overflow;
`ifdef BUS_UART_PARITY_EN
  logic        parity_bit;
`endif

  logic          hit_data;
  logic          hit_status;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          ovf_set;
  logic          status_rd;
  logic          data_rd;
  logic          baud_zero;
  logic          busy;
  logic [7:0]    status_word;

  // Bus decode: writes to the data register push unless the FIFO is already full.
  assign hit_data   = (addressBus == BASE_ADDR + OFS_DATA);
  assign hit_status = (addressBus == BASE_ADDR + OFS_STATUS);
  assign fifo_push  = writeEnBus && hit_data && !fifo_full;
  assign ovf_set    = writeEnBus && hit_data && fifo_full;
  assign status_rd  = !writeEnBus && hit_status;
  assign data_rd    = !writeEnBus && hit_data;

  assign baud_zero = (baud_cnt == 16'd0);
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  // Pop when a new frame starts: from IDLE, or at the last clock of STOP for gapless frames.
  assign fifo_pop = !fifo_empty &&
                    ((state == S_IDLE) || ((state == S_STOP) && baud_zero));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (data_c2r),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Assemble the status word from its named bit positions.
  always_comb begin
    status_word          = 8'h00;
    status_word[ST_BUSY] = busy;
    status_word[ST_FULL] = fifo_full;
    status_word[ST_OVF]  = overflow;
  end

  // Sticky overflow flag: set by a dropped write, cleared by a status read; set wins.
  always_ff @(posedge clock) begin
    if (reset)          overflow <= 1'b0;
    else if (ovf_set)   overflow <= 1'b1;
    else if (status_rd) overflow <= 1'b0;
  end

  // Registered read port: one clock of latency, rd_sel flags a hit on either register.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_r2c <= 8'h00;
      rd_sel   <= 1'b0;
    end else begin
      rd_sel   <= status_rd || data_rd;
      data_r2c <= status_rd ? status_word : 8'h00;
    end
  end

  // Transmit FSM with baud counter and shift register; tx is registered.
  // The FIFO read data arrives one clock after the pop, so the shift register
  // is loaded during the start bit (BAUD_DIV >= 2 guarantees it is in time).
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      tx           <= 1'b1;
      baud_cnt     <= 16'd0;
      bit_idx      <= 3'd0;
      shift_reg    <= 8'h00;
      load_pending <= 1'b0;
`ifdef BUS_UART_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      load_pending <= fifo_pop;
      if (load_pending) begin
        shift_reg  <= fifo_rd_data;
`ifdef BUS_UART_PARITY_EN
        parity_bit <= even_parity(fifo_rd_data);
`endif
      end
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state    <= S_START;
            tx       <= 1'b0;
            baud_cnt <= BAUD_LOAD;
          end
        end
        S_START: begin
          if (baud_zero) begin
            state    <= S_DATA;
            tx       <= shift_reg[0];
            bit_idx  <= 3'd0;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef BUS_UART_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`ifdef BUS_UART_PARITY_EN
        S_PARITY: begin
          if (baud_zero) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            baud_cnt <= BAUD_LOAD;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_zero) begin
            if (!fifo_empty) begin
              state    <= S_START;
              tx       <= 1'b0;
              baud_cnt <= BAUD_LOAD;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed testbench for bus_uart_tx with BAUD_DIV=4, FIFO_DEPTH=16.
// Build with BUS_UART_PARITY_EN defined to exercise the parity frame format.
module tb_bus_uart_tx;

  localparam logic [15:0] BASE  = 16'hF200;
  localparam int          BD    = 4;
  localparam int          DEPTH = 16;
`ifdef BUS_UART_PARITY_EN
  localparam int          NB    = 11;
`else
  localparam int          NB    = 10;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] addressBus;
  logic        writeEnBus;
  logic [7:0]  data_c2r;
  logic [7:0]  data_r2c;
  logic        rd_sel;
  logic        tx;

  int checks = 0;
  int errors = 0;

  bus_uart_tx #(
    .BASE_ADDR  (BASE),
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .addressBus (addressBus),
    .writeEnBus (writeEnBus),
    .data_c2r   (data_c2r),
    .data_r2c   (data_r2c),
    .rd_sel     (rd_sel),
    .tx         (tx)
  );

  // Clock and watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Advance to just after the next rising edge; all driving and sampling happens here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addressBus = a;
    data_c2r   = d;
    writeEnBus = 1'b1;
    tick();
    writeEnBus = 1'b0;
    addressBus = 16'h0000;
    data_c2r   = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
    addressBus = a;
    writeEnBus = 1'b0;
    tick();
    d = data_r2c;
    s = rd_sel;
    addressBus = 16'h0000;
  endtask

  // Expected line levels, LSB first: start, 8 data bits, [parity], stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic par);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef BUS_UART_PARITY_EN
    f[9]   = par;
`else
    f[9]   = 1'b1 | par;
`endif
    return f;
  endfunction

  // Sample tx for NB*BD clocks starting at the next edge; every clock of a bit must match.
  task automatic check_frame(input logic [7:0] b, input logic par, input string name);
    logic [10:0] exp_f;
    logic [10:0] obs_f;
    logic        bad;
    exp_f = frame_bits(b, par);
    obs_f = '1;
    bad   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      for (int k = 0; k < BD; k++) begin
        tick();
        if (k == 0) obs_f[i] = tx;
        if (tx !== exp_f[i]) bad = 1'b1;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: tx frame (LSB first, sampled) got %b required %b or unstable within a bit",
               name, obs_f[NB-1:0], exp_f[NB-1:0]);
    end
  endtask

  task automatic check_idle(input int n, input string name);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: tx left idle level during %0d idle clocks (required constant 1)", name, n);
    end
  endtask

  task automatic check_status(input logic [7:0] exp_d, input string name);
    logic [7:0] d;
    logic       s;
    bus_read(BASE + 16'd1, d, s);
    checks++;
    if (d !== exp_d || s !== 1'b1) begin
      errors++;
      $display("FAIL %s: status got data=%h rd_sel=%b required data=%h rd_sel=1", name, d, s, exp_d);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    writeEnBus = 1'b0;
    addressBus = 16'h0000;
    data_c2r   = 8'h00;
    tick();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++;
    if (data_r2c !== 8'h00) begin errors++; $display("FAIL reset_data_r2c: got %h required 00", data_r2c); end
    checks++;
    if (rd_sel !== 1'b0) begin errors++; $display("FAIL reset_rd_sel: got %b required 0", rd_sel); end
    reset = 1'b0;
    check_idle(50, "reset_idle_tx");
    check_status(8'h00, "reset_status");
    tick();
    checks++;
    if (rd_sel !== 1'b0) begin errors++; $display("FAIL rd_sel_hold: got %b required 0 one cycle after read", rd_sel); end
  endtask

  task automatic test_bus_decode();
    logic [7:0] d;
    logic       s;
    bus_read(BASE, d, s);
    checks++;
    if (d !== 8'h00 || s !== 1'b1) begin
      errors++;
      $display("FAIL data_reg_read: got data=%h rd_sel=%b required data=00 rd_sel=1", d, s);
    end
    bus_read(16'h1234, d, s);
    checks++;
    if (d !== 8'h00 || s !== 1'b0) begin
      errors++;
      $display("FAIL foreign_read: got data=%h rd_sel=%b required data=00 rd_sel=0", d, s);
    end
    bus_read(BASE + 16'd2, d, s);
    checks++;
    if (d !== 8'h00 || s !== 1'b0) begin
      errors++;
      $display("FAIL base_plus2_read: got data=%h rd_sel=%b required data=00 rd_sel=0", d, s);
    end
    bus_write(BASE + 16'd1, 8'hFF);
    bus_write(16'hF1FF, 8'h55);
    check_idle(3 * BD, "ignored_write_tx");
    check_status(8'h00, "ignored_write_status");
  endtask

  task automatic test_single_byte();
    bus_write(BASE, 8'hA5);
    fork
      check_status(8'h01, "single_busy");
      check_frame(8'hA5, 1'b0, "single_a5");
    join
    tick();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL single_after_stop: tx got %b required 1", tx); end
    check_status(8'h00, "single_not_busy");
  endtask

  task automatic test_back_to_back();
    bus_write(BASE, 8'h00);
    fork
      bus_write(BASE, 8'hFF);
      begin
        check_frame(8'h00, 1'b0, "b2b_first_00");
        check_frame(8'hFF, 1'b0, "b2b_second_ff");
      end
    join
    check_idle(2 * BD, "b2b_idle_after");
    check_status(8'h00, "b2b_status");
  endtask

  task automatic test_overflow();
    bus_write(BASE, 8'h80);
    fork
      begin
        for (int i = 0; i < DEPTH; i++) bus_write(BASE, 8'h40 + 8'(i));
        bus_write(BASE, 8'hEE);
        check_status(8'h07, "ovf_full_set");
        check_status(8'h03, "ovf_cleared");
      end
      begin
        check_frame(8'h80, 1'b1, "ovf_frame_80");
        for (int i = 0; i < DEPTH; i++) check_frame(8'h40 + 8'(i), ^(8'h40 + 8'(i)), "ovf_fill_frame");
      end
    join
    check_idle(3 * NB * BD, "ovf_dropped_never_sent");
    check_status(8'h00, "ovf_final_status");
  endtask

  task automatic test_reset_mid_frame();
    bus_write(BASE, 8'hC3);
    bus_write(BASE, 8'h3C);
    bus_write(BASE, 8'h5A);
    // First write edge E0; tx low from E1; data bit 3 spans E1+16..E1+19. Now just past E2.
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3: tx got %b required 0 (bit 3 of C3)", tx); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b required 1", tx); end
    check_status(8'h00, "midframe_reset_status");
    check_idle(50, "midframe_fifo_flushed");
    bus_write(BASE, 8'h96);
    check_frame(8'h96, 1'b0, "midframe_new_96");
    tick();
    check_status(8'h00, "midframe_final_status");
  endtask

`ifdef BUS_UART_PARITY_EN
  task automatic test_parity();
    bus_write(BASE, 8'h07);
    check_frame(8'h07, 1'b1, "parity_07");
    tick();
    bus_write(BASE, 8'h03);
    check_frame(8'h03, 1'b0, "parity_03");
    tick();
    check_status(8'h00, "parity_status");
  endtask
`endif

  initial begin
    test_reset();
    test_bus_decode();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
`ifdef BUS_UART_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
